// File: rtl/nes_palette_pkg.sv
// Shared types and constants for the NES colour pipeline: RGB struct,
// default 2C02 palette, emphasis bit positions and sequencer states.
package nes_palette_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  // Emphasis bus is {B,G,R}
  localparam int EMPH_R = 0;
  localparam int EMPH_G = 1;
  localparam int EMPH_B = 2;

  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam rgb888_t DEFAULT_PALETTE [64] = '{
    24'h7C7C7C, 24'h0000FC, 24'h0000BC, 24'h4428BC,
    24'h940084, 24'hA80020, 24'hA81000, 24'h881400,
    24'h503000, 24'h007800, 24'h006800, 24'h005800,
    24'h004058, 24'h000000, 24'h000000, 24'h000000,
    24'hBCBCBC, 24'h0078F8, 24'h0058F8, 24'h6844FC,
    24'hD800CC, 24'hE40058, 24'hF83800, 24'hE45C10,
    24'hAC7C00, 24'h00B800, 24'h00A800, 24'h00A844,
    24'h008888, 24'h000000, 24'h000000, 24'h000000,
    24'hF8F8F8, 24'h3CBCFC, 24'h6888FC, 24'h9878F8,
    24'hF878F8, 24'hF85898, 24'hF87858, 24'hFCA044,
    24'hF8B800, 24'hB8F818, 24'h58D854, 24'h58F898,
    24'h00E8D8, 24'h787878, 24'h000000, 24'h000000,
    24'hFCFCFC, 24'hA4E4FC, 24'hB8B8F8, 24'hD8B8F8,
    24'hF8B8F8, 24'hF8A4C0, 24'hF0D0B0, 24'hFCE0A8,
    24'hF8D878, 24'hD8F878, 24'hB8F8B8, 24'hB8F8D8,
    24'h00FCFC, 24'hF8D8F8, 24'h000000, 24'h000000
  };

endpackage

// File: rtl/nes_palette_ram.sv
// 64x24 palette storage: one write port, one synchronous read-first read port.
module nes_palette_ram
  import nes_palette_pkg::*;
(
  input  logic       ppu_clock,
  input  logic       we,
  input  logic [5:0] waddr,
  input  rgb888_t    wdata,
  input  logic       re,
  input  logic [5:0] raddr,
  output rgb888_t    rdata
);

  rgb888_t mem [64];

  // Both in one block so a colliding read returns the pre-write contents
  always_ff @(posedge ppu_clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/nes_color_pipeline.sv
// PPU index -> RGB converter: writable palette RAM with a default-load
// sequencer, followed by a 3-stage valid/ready colour pipeline with sideband.
module nes_color_pipeline
  import nes_palette_pkg::*;
#(
  parameter int OUT_W         = 8,
  parameter int COORD_W       = 8,
  parameter int ATTEN         = 192,
  parameter int INIT_ON_RESET = 1
) (
  input  logic               ppu_clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [5:0]         nes_color,
  input  logic               grayscale,
  input  logic [2:0]         emphasis,
  input  logic               rendering_enabled,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               vga_we,
  input  logic               vga_swap_buffers,
  input  logic               pal_we,
  input  logic [5:0]         pal_addr,
  input  logic [23:0]        pal_data,
  input  logic               pal_reload,
  output logic               init_busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W-1:0]   red,
  output logic [OUT_W-1:0]   green,
  output logic [OUT_W-1:0]   blue,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               vga_we_out,
  output logic               vga_swap_buffers_out
);

  localparam logic [7:0] ATTEN8 = ATTEN[7:0];

  logic [0:0] state;
  logic [5:0] init_cnt;

  logic       adv;
  logic       accept;

  logic               s1_valid;
  logic [5:0]         s1_idx;
  logic [2:0]         s1_emph;
  logic               s1_ren;
  logic [COORD_W-1:0] s1_x, s1_y;
  logic               s1_we, s1_swap;

  logic               s2_valid;
  logic [2:0]         s2_emph;
  logic               s2_ren;
  logic [COORD_W-1:0] s2_x, s2_y;
  logic               s2_we, s2_swap;

  logic               s3_valid;

  logic       ram_we;
  logic [5:0] ram_waddr;
  rgb888_t    ram_wdata;
  rgb888_t    pal_q;

  logic       dim_r, dim_g, dim_b;
  logic [7:0] sh_r, sh_g, sh_b;
  logic [OUT_W-1:0] sc_r, sc_g, sc_b;

  // Sequencer writes one default entry per cycle; 63 -> RUN, so INIT lasts 64 cycles
  always_ff @(posedge ppu_clock or posedge reset) begin
    if (reset) begin
      state    <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_cnt <= '0;
    end else if (state == INIT) begin
      init_cnt <= init_cnt + 6'd1;
      if (init_cnt == 6'd63) state <= RUN;
    end else if (pal_reload) begin
      state    <= INIT;
      init_cnt <= '0;
    end
  end

  assign init_busy = (state == INIT);
  assign ram_we    = init_busy ? 1'b1 : pal_we;
  assign ram_waddr = init_busy ? init_cnt : pal_addr;
  assign ram_wdata = init_busy ? DEFAULT_PALETTE[init_cnt] : rgb888_t'(pal_data);

  assign adv       = !s3_valid || out_ready;
  assign in_ready  = adv && (state == RUN);
  assign accept    = in_valid && in_ready;
  assign out_valid = s3_valid;

  nes_palette_ram u_ram (
    .ppu_clock (ppu_clock),
    .we        (ram_we),
    .waddr     (ram_waddr),
    .wdata     (ram_wdata),
    .re        (adv),
    .raddr     (s1_idx),
    .rdata     (pal_q)
  );

  // Grayscale keeps only the luma row of the index
  always_ff @(posedge ppu_clock or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_idx   <= '0;
      s1_emph  <= '0;
      s1_ren   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_we    <= 1'b0;
      s1_swap  <= 1'b0;
    end else if (adv) begin
      s1_valid <= accept;
      s1_idx   <= grayscale ? (nes_color & 6'h30) : nes_color;
      s1_emph  <= emphasis;
      s1_ren   <= rendering_enabled;
      s1_x     <= x;
      s1_y     <= y;
      s1_we    <= vga_we;
      s1_swap  <= vga_swap_buffers;
    end
  end

  always_ff @(posedge ppu_clock or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_emph  <= '0;
      s2_ren   <= 1'b0;
      s2_x     <= '0;
      s2_y     <= '0;
      s2_we    <= 1'b0;
      s2_swap  <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
      s2_emph  <= s1_emph;
      s2_ren   <= s1_ren;
      s2_x     <= s1_x;
      s2_y     <= s1_y;
      s2_we    <= s1_we;
      s2_swap  <= s1_swap;
    end
  end

  function automatic logic [7:0] attenuate(input logic [7:0] c);
    logic [15:0] p;
    p = {8'd0, c} * {8'd0, ATTEN8};
    return p[15:8];
  endfunction

  // Each emphasis bit darkens the two channels other than its own
  assign dim_r = s2_emph[EMPH_G] | s2_emph[EMPH_B];
  assign dim_g = s2_emph[EMPH_B] | s2_emph[EMPH_R];
  assign dim_b = s2_emph[EMPH_R] | s2_emph[EMPH_G];

  assign sh_r = !s2_ren ? 8'd0 : (dim_r ? attenuate(pal_q.r) : pal_q.r);
  assign sh_g = !s2_ren ? 8'd0 : (dim_g ? attenuate(pal_q.g) : pal_q.g);
  assign sh_b = !s2_ren ? 8'd0 : (dim_b ? attenuate(pal_q.b) : pal_q.b);

  generate
    if (OUT_W <= 8) begin : g_trunc
      assign sc_r = sh_r[7 -: OUT_W];
      assign sc_g = sh_g[7 -: OUT_W];
      assign sc_b = sh_b[7 -: OUT_W];
    end else begin : g_replicate
      assign sc_r = {sh_r, sh_r[7 -: OUT_W-8]};
      assign sc_g = {sh_g, sh_g[7 -: OUT_W-8]};
      assign sc_b = {sh_b, sh_b[7 -: OUT_W-8]};
    end
  endgenerate

  always_ff @(posedge ppu_clock or posedge reset) begin
    if (reset) begin
      s3_valid             <= 1'b0;
      red                  <= '0;
      green                <= '0;
      blue                 <= '0;
      x_out                <= '0;
      y_out                <= '0;
      vga_we_out           <= 1'b0;
      vga_swap_buffers_out <= 1'b0;
    end else if (adv) begin
      s3_valid             <= s2_valid;
      red                  <= sc_r;
      green                <= sc_g;
      blue                 <= sc_b;
      x_out                <= s2_x;
      y_out                <= s2_y;
      vga_we_out           <= s2_we;
      vga_swap_buffers_out <= s2_swap;
    end
  end

endmodule

// File: tb/tb_nes_color_pipeline.sv
// Directed bench for nes_color_pipeline: an 8-bit and a 10-bit instance
// share all stimulus; expected colours are hand-computed constants.
module tb_nes_color_pipeline;

  logic       ppu_clock = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [5:0] nes_color = '0;
  logic       grayscale = 1'b0;
  logic [2:0] emphasis = '0;
  logic       rendering_enabled = 1'b1;
  logic [7:0] x = '0;
  logic [7:0] y = '0;
  logic       vga_we = 1'b0;
  logic       vga_swap_buffers = 1'b0;
  logic       pal_we = 1'b0;
  logic [5:0] pal_addr = '0;
  logic [23:0] pal_data = '0;
  logic       pal_reload = 1'b0;
  logic       out_ready = 1'b1;

  logic       in_ready, init_busy, out_valid;
  logic [7:0] red, green, blue, x_out, y_out;
  logic       vga_we_out, vga_swap_buffers_out;

  logic       w_in_ready, w_init_busy, w_out_valid;
  logic [9:0] w_red, w_green, w_blue;
  logic [7:0] w_x_out, w_y_out;
  logic       w_vga_we_out, w_vga_swap_buffers_out;

  int checks = 0;
  int errors = 0;

  always #5 ppu_clock = ~ppu_clock;

  nes_color_pipeline #(.OUT_W(8)) dut (
    .ppu_clock(ppu_clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .nes_color(nes_color), .grayscale(grayscale), .emphasis(emphasis),
    .rendering_enabled(rendering_enabled), .x(x), .y(y), .vga_we(vga_we),
    .vga_swap_buffers(vga_swap_buffers), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .pal_reload(pal_reload), .init_busy(init_busy),
    .out_valid(out_valid), .out_ready(out_ready), .red(red), .green(green), .blue(blue),
    .x_out(x_out), .y_out(y_out), .vga_we_out(vga_we_out),
    .vga_swap_buffers_out(vga_swap_buffers_out)
  );

  nes_color_pipeline #(.OUT_W(10)) dut10 (
    .ppu_clock(ppu_clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
    .nes_color(nes_color), .grayscale(grayscale), .emphasis(emphasis),
    .rendering_enabled(rendering_enabled), .x(x), .y(y), .vga_we(vga_we),
    .vga_swap_buffers(vga_swap_buffers), .pal_we(pal_we), .pal_addr(pal_addr),
    .pal_data(pal_data), .pal_reload(pal_reload), .init_busy(w_init_busy),
    .out_valid(w_out_valid), .out_ready(out_ready), .red(w_red), .green(w_green),
    .blue(w_blue), .x_out(w_x_out), .y_out(w_y_out), .vga_we_out(w_vga_we_out),
    .vga_swap_buffers_out(w_vga_swap_buffers_out)
  );

  task automatic send_pixel(input logic [5:0] c, input logic gs, input logic [2:0] e,
                            input logic ren, input logic [7:0] px, input logic [7:0] py,
                            input logic pw, input logic ps, output int lat);
    @(negedge ppu_clock);
    nes_color = c; grayscale = gs; emphasis = e; rendering_enabled = ren;
    x = px; y = py; vga_we = pw; vga_swap_buffers = ps; in_valid = 1'b1;
    @(negedge ppu_clock);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge ppu_clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    int busy_cycles;
    int ready_during_init;
    busy_cycles = 0;
    ready_during_init = 0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({out_valid, red, green, blue, x_out, y_out, vga_we_out, vga_swap_buffers_out} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b rgb=%h%h%h want all zero", out_valid, red, green, blue);
    end
    checks++;
    if (init_busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy: got %b want 1", init_busy);
    end
    repeat (2) @(negedge ppu_clock);
    reset = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (init_busy !== 1'b1) break;
      busy_cycles++;
      if (in_ready !== 1'b0) ready_during_init++;
      @(negedge ppu_clock);
    end
    checks++;
    if (busy_cycles != 64) begin
      errors++;
      $display("[TB] FAIL init_length: got %0d cycles want 64", busy_cycles);
    end
    checks++;
    if (ready_during_init != 0) begin
      errors++;
      $display("[TB] FAIL init_in_ready: got %0d ready cycles want 0", ready_during_init);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL run_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_lookup();
    int lat;
    send_pixel(6'h01, 1'b0, 3'b000, 1'b1, 8'h12, 8'h34, 1'b1, 1'b1, lat);
    checks++;
    if (lat != 3) begin
      errors++;
      $display("[TB] FAIL lookup_latency: got %0d want 3", lat);
    end
    checks++;
    if ({red, green, blue} !== 24'h0000FC) begin
      errors++;
      $display("[TB] FAIL lookup_rgb: got %h want 0000fc", {red, green, blue});
    end
    checks++;
    if ({x_out, y_out, vga_we_out, vga_swap_buffers_out} !== {8'h12, 8'h34, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL lookup_sideband: got x=%h y=%h we=%b swap=%b want 12 34 1 1",
               x_out, y_out, vga_we_out, vga_swap_buffers_out);
    end
    checks++;
    if ({w_red, w_green, w_blue} !== {10'h000, 10'h000, 10'h3F3}) begin
      errors++;
      $display("[TB] FAIL lookup_wide: got %h %h %h want 000 000 3f3", w_red, w_green, w_blue);
    end
    @(negedge ppu_clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lookup_single: got out_valid=%b want 0", out_valid);
    end
    send_pixel(6'h02, 1'b0, 3'b000, 1'b1, 8'hA5, 8'h5A, 1'b0, 1'b1, lat);
    checks++;
    if ({red, green, blue, x_out, y_out, vga_we_out, vga_swap_buffers_out} !==
        {24'h0000BC, 8'hA5, 8'h5A, 1'b0, 1'b1}) begin
      errors++;
      $display("[TB] FAIL lookup_second: got %h x=%h y=%h we=%b swap=%b want 0000bc a5 5a 0 1",
               {red, green, blue}, x_out, y_out, vga_we_out, vga_swap_buffers_out);
    end
  endtask

  task automatic test_emphasis();
    logic [2:0]  emph_vec [4] = '{3'b001, 3'b111, 3'b010, 3'b100};
    logic [23:0] want_vec [4] = '{24'hFCBDBD, 24'hBDBDBD, 24'hBDFCBD, 24'hBDBDFC};
    int lat;
    for (int i = 0; i < 4; i++) begin
      send_pixel(6'h30, 1'b0, emph_vec[i], 1'b1, 8'(i), 8'h00, 1'b0, 1'b0, lat);
      checks++;
      if (lat != 3 || {red, green, blue} !== want_vec[i]) begin
        errors++;
        $display("[TB] FAIL emphasis_%b: got %h lat=%0d want %h lat=3", emph_vec[i],
                 {red, green, blue}, lat, want_vec[i]);
      end
    end
  endtask

  task automatic test_grayscale_blank();
    int lat;
    send_pixel(6'h16, 1'b1, 3'b000, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0, lat);
    checks++;
    if ({red, green, blue} !== 24'hBCBCBC) begin
      errors++;
      $display("[TB] FAIL grayscale_16: got %h want bcbcbc", {red, green, blue});
    end
    send_pixel(6'h3C, 1'b1, 3'b000, 1'b1, 8'h03, 8'h04, 1'b0, 1'b0, lat);
    checks++;
    if ({red, green, blue} !== 24'hFCFCFC) begin
      errors++;
      $display("[TB] FAIL grayscale_3c: got %h want fcfcfc", {red, green, blue});
    end
    send_pixel(6'h01, 1'b0, 3'b000, 1'b0, 8'h05, 8'h06, 1'b1, 1'b0, lat);
    checks++;
    if (lat != 3 || {red, green, blue} !== 24'h000000 || x_out !== 8'h05) begin
      errors++;
      $display("[TB] FAIL blanked: got %h x=%h lat=%0d want 000000 x=05 lat=3",
               {red, green, blue}, x_out, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  col [10] = '{6'h01, 6'h02, 6'h06, 6'h10, 6'h11, 6'h16, 6'h20, 6'h21, 6'h30, 6'h0D};
    logic [23:0] want [10] = '{24'h0000FC, 24'h0000BC, 24'hA81000, 24'hBCBCBC, 24'h0078F8,
                               24'hF83800, 24'hF8F8F8, 24'h3CBCFC, 24'hFCFCFC, 24'h000000};
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [39:0] held_val;
    logic        held;
    int tx, rx;
    tx = 0; rx = 0; held = 1'b0; held_val = '0;
    grayscale = 1'b0; emphasis = 3'b000; rendering_enabled = 1'b1;
    for (int cyc = 0; cyc < 300 && rx < 10; cyc++) begin
      @(negedge ppu_clock);
      out_ready = pat[cyc % 4];
      if (tx < 10) begin
        nes_color = col[tx]; x = 8'(tx); y = 8'(tx + 100); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (held) begin
        checks++;
        if ({x_out, out_valid, red, green, blue, 7'd0} !== held_val) begin
          errors++;
          $display("[TB] FAIL stall_stable: got %h want %h", {x_out, out_valid, red, green, blue, 7'd0}, held_val);
        end
      end
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          checks++;
          if ({x_out, y_out, red, green, blue} !== {8'(rx), 8'(rx + 100), want[rx]}) begin
            errors++;
            $display("[TB] FAIL stream_px%0d: got x=%h y=%h rgb=%h want x=%h rgb=%h",
                     rx, x_out, y_out, {red, green, blue}, 8'(rx), want[rx]);
          end
          rx++;
        end else begin
          held = 1'b1;
          held_val = {x_out, out_valid, red, green, blue, 7'd0};
        end
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (rx != 10) begin
      errors++;
      $display("[TB] FAIL stream_count: got %0d pixels want 10", rx);
    end
    repeat (2) @(negedge ppu_clock);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_extra: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_palette_write();
    int lat;
    @(negedge ppu_clock);
    pal_we = 1'b1; pal_addr = 6'h05; pal_data = 24'h123456;
    @(negedge ppu_clock);
    pal_we = 1'b0;
    send_pixel(6'h05, 1'b0, 3'b000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, lat);
    checks++;
    if ({red, green, blue} !== 24'h123456) begin
      errors++;
      $display("[TB] FAIL palette_write: got %h want 123456", {red, green, blue});
    end
  endtask

  task automatic test_reload();
    int busy_cycles;
    int ready_during_init;
    int lat;
    busy_cycles = 0;
    ready_during_init = 0;
    @(negedge ppu_clock);
    pal_reload = 1'b1;
    @(negedge ppu_clock);
    pal_reload = 1'b0;
    pal_addr = 6'h05; pal_data = 24'hFFFFFF;
    for (int i = 0; i < 200; i++) begin
      pal_we = (i >= 10 && i < 13);
      #1;
      if (init_busy !== 1'b1) break;
      busy_cycles++;
      if (in_ready !== 1'b0) ready_during_init++;
      @(negedge ppu_clock);
    end
    pal_we = 1'b0;
    checks++;
    if (busy_cycles != 64 || ready_during_init != 0) begin
      errors++;
      $display("[TB] FAIL reload_init: got %0d busy, %0d ready want 64 busy, 0 ready",
               busy_cycles, ready_during_init);
    end
    send_pixel(6'h05, 1'b0, 3'b000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, lat);
    checks++;
    if (lat != 3 || {red, green, blue} !== 24'hA80020) begin
      errors++;
      $display("[TB] FAIL reload_05: got %h lat=%0d want a80020 lat=3", {red, green, blue}, lat);
    end
    send_pixel(6'h20, 1'b0, 3'b000, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0, lat);
    checks++;
    if ({w_red, w_green, w_blue} !== {10'h3E3, 10'h3E3, 10'h3E3} || {red, green, blue} !== 24'hF8F8F8) begin
      errors++;
      $display("[TB] FAIL wide_20: got %h %h %h / %h want 3e3 3e3 3e3 / f8f8f8",
               w_red, w_green, w_blue, {red, green, blue});
    end
  endtask

  initial begin
    test_reset();
    test_lookup();
    test_emphasis();
    test_grayscale_blank();
    test_back_to_back();
    test_palette_write();
    test_reload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
